// File: rtl/entry_sequencer.sv
// Debounced pushbutton digit-entry sequencer: captures sw_digit on each accepted press, up to four digits.
// Optional ENTRY_AUTOCLEAR_EN: a press while full clears the entry instead of being ignored.
module entry_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2      // legal range 2..3
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        key_n,
    input  logic [3:0]  sw_digit,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic        entry_done,
    output logic        full,
    output logic        busy
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       MAX_DIGITS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRESS_DB = 3'd1,
        S_CAPTURE  = 3'd2,
        S_WAIT_REL = 3'd3,
        S_REL_DB   = 3'd4,
        S_FULL     = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
    logic [15:0]            digits_q, digits_d;
    logic [2:0]             count_q, count_d;
    logic                   done_q, done_d;
    logic                   kp;

    // Synchronizer resets to the released level so a held key is seen as a fresh press.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
        end
    end

    assign kp = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= S_IDLE;
            db_cnt_q <= '0;
            digits_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        digits_d = digits_q;
        count_d  = count_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (kp) begin
                    state_d  = S_PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            S_PRESS_DB: begin
                if (!kp) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == CNT_MAX) begin
                    state_d = S_CAPTURE;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
`ifdef ENTRY_AUTOCLEAR_EN
                if (count_q == MAX_DIGITS) begin
                    digits_d = '0;
                    count_d  = '0;
                end else begin
                    digits_d = {digits_q[11:0], sw_digit};
                    count_d  = count_q + 3'd1;
                end
`else
                digits_d = {digits_q[11:0], sw_digit};
                if (count_q != MAX_DIGITS) begin
                    count_d = count_q + 3'd1;
                end
`endif
                done_d  = 1'b1;
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!kp) begin
                    state_d  = S_REL_DB;
                    db_cnt_d = '0;
                end
            end
            S_REL_DB: begin
                if (kp) begin
                    state_d = S_WAIT_REL;
                end else if (db_cnt_q == CNT_MAX) begin
                    state_d = (count_q == MAX_DIGITS) ? S_FULL : S_IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            S_FULL: begin
`ifdef ENTRY_AUTOCLEAR_EN
                if (kp) begin
                    state_d  = S_PRESS_DB;
                    db_cnt_d = '0;
                end
`endif
            end
            default: begin
                state_d  = S_IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    assign digits      = digits_q;
    assign digit_count = count_q;
    assign entry_done  = done_q;
    assign full        = (state_q == S_FULL);
    assign busy        = (state_q != S_IDLE) && (state_q != S_FULL);

endmodule

// File: tb/tb_entry_sequencer.sv
// Bench for entry_sequencer: directed scenarios plus random key activity, checked every cycle
// against a run-length model of the debounce/capture rules.
module tb_entry_sequencer;

    localparam int unsigned DB   = 4;
    localparam int unsigned SYNC = 2;
`ifdef ENTRY_AUTOCLEAR_EN
    localparam bit AUTOCLR = 1'b1;
`else
    localparam bit AUTOCLR = 1'b0;
`endif
    localparam int PH_ARMED = 0;
    localparam int PH_CAPT  = 1;
    localparam int PH_REL   = 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        key_n = 1'b1;
    logic [3:0]  sw    = 4'h0;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        entry_done;
    logic        full;
    logic        busy;

    entry_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .key_n      (key_n),
        .sw_digit   (sw),
        .digits     (digits),
        .digit_count(digit_count),
        .entry_done (entry_done),
        .full       (full),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: key level delayed by SYNC samples, then run lengths of stable levels.
    bit          kn_hist[$];
    logic [15:0] m_digits = '0;
    int          m_count  = 0;
    bit          m_done   = 1'b0;
    bit          m_full   = 1'b0;
    int          m_phase  = PH_ARMED;
    int          m_run    = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit kp;
        if (rst) begin
            m_digits = '0; m_count = 0; m_done = 1'b0; m_full = 1'b0;
            m_phase = PH_ARMED; m_run = 0;
            kn_hist.delete();
            for (int i = 0; i < int'(SYNC); i++) kn_hist.push_back(1'b1);
            return;
        end
        kp = !kn_hist.pop_front();
        kn_hist.push_back(key_n);
        m_done = 1'b0;
        case (m_phase)
            PH_ARMED: begin
                if (!(m_full && !AUTOCLR)) begin
                    if (kp) begin
                        m_full = 1'b0;
                        m_run++;
                        if (m_run == int'(DB) + 1) begin
                            m_phase = PH_CAPT;
                            m_run   = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
            end
            PH_CAPT: begin
                if (m_count == 4) begin
                    m_digits = '0;
                    m_count  = 0;
                end else begin
                    m_digits = {m_digits[11:0], sw};
                    m_count++;
                end
                m_done  = 1'b1;
                m_phase = PH_REL;
                m_run   = 0;
            end
            default: begin
                if (!kp) begin
                    m_run++;
                    if (m_run == int'(DB) + 1) begin
                        m_phase = PH_ARMED;
                        m_run   = 0;
                        m_full  = (m_count == 4);
                    end
                end else begin
                    m_run = 0;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("digits", digits, m_digits);
        chk("digit_count", 16'(digit_count), 16'(m_count));
        chk("entry_done", 16'(entry_done), 16'(m_done));
        chk("full", 16'(full), 16'(m_full));
        chk("busy", 16'(busy), 16'((m_phase != PH_ARMED) || (m_run > 0)));
    endtask

    task automatic press(input logic [3:0] d, output int pulses);
        pulses = 0;
        sw     = d;
        key_n  = 1'b0;
        repeat (SYNC + DB + 6) begin tick(); if (entry_done === 1'b1) pulses++; end
        key_n = 1'b1;
        repeat (SYNC + DB + 6) begin tick(); if (entry_done === 1'b1) pulses++; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        int len;

        rst = 1'b1; key_n = 1'b1; sw = 4'h0;
        repeat (3) tick();
        chk("rst_digits", digits, 16'h0000);
        chk("rst_count", 16'(digit_count), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        tick();

        // Short press (3 cycles) is rejected as bounce.
        key_n = 1'b0;
        repeat (3) tick();
        key_n = 1'b1;
        repeat (12) tick();
        chk("bounce_digits", digits, 16'h0000);
        chk("bounce_busy", 16'(busy), 16'h0);

        // Held press: capture latency and single capture.
        sw = 4'h7; key_n = 1'b0; lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (entry_done === 1'b1) break;
        end
        chk("latency", 16'(lat), 16'(SYNC + DB + 2));
        chk("first_digits", digits, 16'h0007);
        chk("first_count", 16'(digit_count), 16'h1);
        chk("first_busy", 16'(busy), 16'h1);
        repeat (20) begin sw = 4'($urandom); tick(); end
        chk("hold_count", 16'(digit_count), 16'h1);
        chk("hold_busy", 16'(busy), 16'h1);
        key_n = 1'b1;
        repeat (SYNC + DB + 3) tick();
        chk("release_busy", 16'(busy), 16'h0);

        // Release chatter: no second capture, release accepted only after a stable run.
        press_hold_chatter();
        chk("chatter_digits", digits, 16'h0075);
        chk("chatter_count", 16'(digit_count), 16'h2);

        // Four digits fill the entry; a fifth press is ignored or clears.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int i = 1; i <= 4; i++) begin
            press(4'(i), pulses);
            chk("press_pulses", 16'(pulses), 16'h1);
        end
        chk("fill_digits", digits, 16'h1234);
        chk("fill_count", 16'(digit_count), 16'h4);
        chk("fill_full", 16'(full), 16'h1);
        chk("fill_busy", 16'(busy), 16'h0);
        press(4'hA, pulses);
        chk("fifth_pulses", 16'(pulses), AUTOCLR ? 16'h1 : 16'h0);
        chk("fifth_digits", digits, AUTOCLR ? 16'h0000 : 16'h1234);
        chk("fifth_count", 16'(digit_count), AUTOCLR ? 16'h0 : 16'h4);
        chk("fifth_full", 16'(full), AUTOCLR ? 16'h0 : 16'h1);

        // Reset mid-debounce aborts; a key held through reset is a new press.
        rst = 1'b1; tick(); rst = 1'b0;
        press(4'hE, pulses);
        press(4'hF, pulses);
        chk("pre_abort_digits", digits, 16'h00EF);
        sw = 4'h3; key_n = 1'b0;
        repeat (SYNC + 2) tick();
        chk("abort_busy_before", 16'(busy), 16'h1);
        rst = 1'b1;
        tick();
        chk("abort_digits", digits, 16'h0000);
        chk("abort_count", 16'(digit_count), 16'h0);
        chk("abort_done", 16'(entry_done), 16'h0);
        chk("abort_busy", 16'(busy), 16'h0);
        rst = 1'b0; lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (entry_done === 1'b1) break;
        end
        chk("held_reset_latency", 16'(lat), 16'(SYNC + DB + 2));
        chk("held_reset_digits", digits, 16'h0003);
        key_n = 1'b1;
        repeat (SYNC + DB + 3) tick();

        // Random key activity with occasional reset; sw changes every cycle.
        for (int i = 0; i < 150; i++) begin
            key_n = 1'($urandom_range(1, 0));
            len   = int'($urandom_range(14, 1));
            for (int j = 0; j < len; j++) begin
                sw  = 4'($urandom);
                rst = ($urandom_range(199, 0) == 0);
                tick();
            end
            rst = 1'b0;
        end
        key_n = 1'b1;
        repeat (SYNC + DB + 4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic press_hold_chatter();
        int lat;
        sw = 4'h5; key_n = 1'b0;
        repeat (SYNC + DB + 4) tick();
        key_n = 1'b1;
        repeat (3) tick();
        key_n = 1'b0; tick();
        key_n = 1'b1; tick();
        key_n = 1'b0; tick();
        key_n = 1'b1; lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (busy === 1'b0) break;
        end
        chk("chatter_release_edges", 16'(lat), 16'(SYNC + DB + 1));
    endtask

endmodule
